// File: rtl/reed_pulse_gen.sv
// Bicycle reed-contact emulator: derives a pulse period from wheel circumference and speed.
// Build option REED_PULSE_GEN_BOUNCE_EN: 1,0,1 contact-bounce pattern, minimum period 4.
module reed_pulse_gen #(
    parameter int unsigned F_CLK = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  circ,
    input  logic [7:0]  speed,
    input  logic        load,
    output logic        reed,
    output logic        busy,
    output logic [15:0] period
);
    // clocks per revolution = circ*36*F_CLK / (speed*1000), rounded by adding D/2 to N
    localparam int unsigned CIRC_SCALE = 36 * F_CLK;
`ifdef REED_PULSE_GEN_BOUNCE_EN
    localparam logic [15:0] MIN_PERIOD = 16'd4;
`else
    localparam logic [15:0] MIN_PERIOD = 16'd2;
`endif

    typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  circ_q, circ_d, speed_q, speed_d;
    logic [17:0] rem_q, rem_d;
    logic [14:0] quo_q, quo_d;
    logic [4:0]  step_q, step_d;
    logic [15:0] cnt_q, cnt_d, period_q, period_d;
    logic        busy_q, busy_d, reed_q, reed_d;
    logic [24:0] num;
    logic [17:0] den;
    logic [18:0] rem_sh;
    logic [15:0] quo_next;
    logic        ge, hit;
`ifdef REED_PULSE_GEN_BOUNCE_EN
    logic [1:0]  seq_q, seq_d;
`endif

    assign num      = 25'(CIRC_SCALE * {24'd0, circ_q} + 32'd500 * {24'd0, speed_q});
    assign den      = 18'(32'd1000 * {24'd0, speed_q});
    assign rem_sh   = {rem_q, num[5'd24 - step_q]};
    assign ge       = rem_sh >= {1'b0, den};
    assign quo_next = {quo_q, ge};
    assign hit      = (period_q != '0) && (cnt_q == period_q - 16'd1);

    always_comb begin
        state_d  = state_q;
        circ_d   = circ_q;
        speed_d  = speed_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        step_d   = step_q;
        busy_d   = busy_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        reed_d   = 1'b0;
`ifdef REED_PULSE_GEN_BOUNCE_EN
        seq_d    = seq_q;
`endif

        // Pulsing follows the applied period, so it keeps going at the old rate during a recompute
        if (period_q != '0) begin
            cnt_d = hit ? '0 : cnt_q + 16'd1;
        end
`ifdef REED_PULSE_GEN_BOUNCE_EN
        if (hit) begin
            reed_d = 1'b1;
            seq_d  = 2'd2;
        end else if (seq_q != '0) begin
            reed_d = (seq_q == 2'd1);
            seq_d  = seq_q - 2'd1;
        end
`else
        reed_d = hit;
`endif

        if (load) begin
            circ_d  = circ;
            speed_d = speed;
            rem_d   = '0;
            quo_d   = '0;
            step_d  = '0;
            if (speed == '0) begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                period_d = '0;
                cnt_d    = '0;
                reed_d   = 1'b0;
`ifdef REED_PULSE_GEN_BOUNCE_EN
                seq_d    = '0;
`endif
            end else begin
                state_d = CALC;
                busy_d  = 1'b1;
            end
        end else begin
            case (state_q)
                CALC: begin
                    rem_d  = ge ? 18'(rem_sh - {1'b0, den}) : rem_sh[17:0];
                    quo_d  = quo_next[14:0];
                    step_d = step_q + 5'd1;
                    if (step_q == 5'd24) begin
                        state_d  = RUN;
                        busy_d   = 1'b0;
                        step_d   = '0;
                        period_d = (quo_next < MIN_PERIOD) ? MIN_PERIOD : quo_next;
                        cnt_d    = '0;
                        reed_d   = 1'b0;
`ifdef REED_PULSE_GEN_BOUNCE_EN
                        seq_d    = '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            circ_q   <= '0;
            speed_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            period_q <= '0;
            cnt_q    <= '0;
            reed_q   <= 1'b0;
`ifdef REED_PULSE_GEN_BOUNCE_EN
            seq_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            circ_q   <= circ_d;
            speed_q  <= speed_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            reed_q   <= reed_d;
`ifdef REED_PULSE_GEN_BOUNCE_EN
            seq_q    <= seq_d;
`endif
        end
    end

    assign reed   = reed_q;
    assign busy   = busy_q;
    assign period = period_q;

endmodule

// File: tb/tb_reed_pulse_gen.sv
// Scoreboard bench for reed_pulse_gen: stimulus queues expected periods, monitor checks pulses.
`timescale 1ns/1ps
module tb_reed_pulse_gen;
`ifdef REED_PULSE_GEN_BOUNCE_EN
    localparam int MINP = 4;
`else
    localparam int MINP = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load  = 1'b0;
    logic [7:0]  circ  = '0;
    logic [7:0]  speed = '0;
    logic        reed, busy;
    logic [15:0] period;

    reed_pulse_gen #(.F_CLK(2048)) dut (
        .clock(clock), .reset(reset), .circ(circ), .speed(speed),
        .load(load), .reed(reed), .busy(busy), .period(period)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int period;
        int busy_len;
    } exp_t;

    exp_t exp_q[$];
    int   stop_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend_valid = 0;
    int   pend_start = 0;
    int   pend_end = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Wheel revolution time in clocks, rounded to nearest, then floored at the minimum period
    function automatic int model_period(input int c, input int s);
        int num, den, q;
        num = c * 36 * 2048;
        den = s * 1000;
        q = (num + den / 2) / den;
        return (q < MINP) ? MINP : q;
    endfunction

    // Called just after a falling edge; the load is sampled at the next rising edge (cycle e)
    task automatic do_load(input int c, input int s);
        int   e;
        bit   pend;
        exp_t x;
        e = cyc + 1;
        pend = pend_valid && (e <= pend_end);
        if (pend) void'(exp_q.pop_back());
        if (s == 0) begin
            stop_q.push_back(e);
            pend_valid = 0;
        end else begin
            if (!pend) pend_start = e;
            pend_end = e + 25;
            pend_valid = 1;
            x.period = model_period(c, s);
            x.busy_len = pend_end - pend_start;
            exp_q.push_back(x);
        end
        circ = 8'(c);
        speed = 8'(s);
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset_mid();
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check(reed == 1'b0, "reset_reed", int'(reed), 0);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check(period == 16'd0, "reset_period", int'(period), 0);
        exp_q.delete();
        stop_q.delete();
        pend_valid = 0;
        wait_cycles(3);
        reset = 1'b1;
    endtask

    initial begin : monitor
        int   mon_period, last_edge, bphase, busy_cnt;
        bit   prev_reed, prev_busy, stopped;
        exp_t x;
        mon_period = 0; last_edge = 0; bphase = 0; busy_cnt = 0;
        prev_reed = 0; prev_busy = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_period = 0; bphase = 0; busy_cnt = 0;
                prev_reed = 0; prev_busy = 0;
                continue;
            end
            stopped = 0;
            if (stop_q.size() > 0 && stop_q[0] == cyc) begin
                void'(stop_q.pop_front());
                mon_period = 0;
                bphase = 0;
                stopped = 1;
                check(busy == 1'b0, "stop_busy", int'(busy), 0);
            end
            if (busy) busy_cnt++;
            if (prev_busy && !busy && !stopped) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_busy_fall", 0, 1);
                end else begin
                    x = exp_q.pop_front();
                    check(int'(period) == x.period, "period_applied", int'(period), x.period);
                    check(busy_cnt == x.busy_len, "busy_len", busy_cnt, x.busy_len);
                    mon_period = x.period;
                    last_edge = cyc;
                    bphase = 0;
                end
            end
            if (!busy) busy_cnt = 0;
            check(int'(period) == mon_period, "period_track", int'(period), mon_period);

            if (bphase == 1) begin
                check(reed == 1'b0, "reed_width", int'(reed), 0);
`ifdef REED_PULSE_GEN_BOUNCE_EN
                bphase = 2;
`else
                bphase = 0;
`endif
            end else if (bphase == 2) begin
                check(reed == 1'b1, "reed_bounce", int'(reed), 1);
                bphase = 0;
            end else if (reed && !prev_reed) begin
                if (mon_period == 0) begin
                    check(1'b0, "reed_while_stopped", 1, 0);
                end else begin
                    check(cyc - last_edge == mon_period, "reed_interval", cyc - last_edge, mon_period);
                    last_edge = cyc;
                    bphase = 1;
                end
            end else if (mon_period != 0 && cyc - last_edge > mon_period) begin
                check(1'b0, "reed_missing", cyc - last_edge, mon_period);
                last_edge = cyc;
            end
            prev_reed = reed;
            prev_busy = busy;
        end
    end

    initial begin : stimulus
        int c, s, gap;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(3);
        check(reed == 1'b0, "init_reed", int'(reed), 0);
        check(busy == 1'b0, "init_busy", int'(busy), 0);
        check(period == 16'd0, "init_period", int'(period), 0);

        do_load(255, 30);  wait_cycles(25 + 627 * 3 + 10);
        do_load(200, 36);  wait_cycles(25 + 410 * 2 + 5);
        do_load(255, 1);   wait_cycles(25 + 18801 + 5);
        do_load(1, 255);   wait_cycles(25 + 20);
        do_load(0, 100);   wait_cycles(25 + 20);

        do_load(255, 30);  wait_cycles(25 + 700);
        do_load(0, 0);     wait_cycles(700);

        do_load(255, 30);  wait_cycles(9);
        do_load(255, 60);  wait_cycles(25 + 313 * 2 + 10);
        do_load(200, 36);  wait_cycles(25 + 410 * 2 + 5);

        do_load(255, 30);  wait_cycles(5);
        do_reset_mid();
        wait_cycles(60);
        check(busy == 1'b0, "idle_after_reset_calc", int'(busy), 0);

        do_load(255, 30);  wait_cycles(25 + 627 + 100);
        do_reset_mid();
        wait_cycles(700);
        check(busy == 1'b0, "idle_after_reset_run", int'(busy), 0);

        for (int i = 0; i < 14; i++) begin
            c = int'($urandom_range(0, 255));
            s = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(20, 255));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30))
                                              : int'($urandom_range(30, 1200));
            do_load(c, s);
            wait_cycles(gap);
        end
        wait_cycles(40);
        check(exp_q.size() == 0, "calc_never_finished", exp_q.size(), 0);
        check(stop_q.size() == 0, "stop_never_seen", stop_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reed_pulse_gen.md
REED_PULSE_GEN -- requirements
Module: reed_pulse_gen

Interface
REQ-001 The block SHALL have parameter F_CLK, default 2048, giving the clock frequency in Hz; the period arithmetic is fixed for 2048.
REQ-002 The block SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port circ, input, 8 bits: wheel circumference in cm, sampled on load.
REQ-005 The block SHALL have port speed, input, 8 bits: target speed in km/h, sampled on load.
REQ-006 The block SHALL have port load, input, 1 bit: one-cycle request to latch circ/speed and recompute.
REQ-007 The block SHALL have port reed, output, 1 bit: emulated reed-contact pulse to the bicycle computer.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the period division runs.
REQ-009 The block SHALL have port period, output, 16 bits: current pulse period in clocks; 0 means stopped.

Function
REQ-010 States SHALL be IDLE (no pulses), CALC (dividing) and RUN (pulsing).
REQ-011 Arithmetic: N = 73728*circ + 500*speed (25 bits), D = 1000*speed (18 bits), Q = floor(N/D), i.e. circ*36*2048/(speed*1000) rounded to nearest.
REQ-012 Division SHALL be restoring, one quotient bit per cycle, 25 cycles, with no combinational divider.
REQ-013 load sampled high with speed != 0 SHALL enter CALC; busy high the next cycle for exactly 25 cycles; period updates on the cycle busy falls; state then goes to RUN.
REQ-014 Period SHALL be clamped: period = max(Q, 2); Q > 65535 cannot occur (max 18801).
REQ-015 load with speed == 0 SHALL go to IDLE the next cycle, set period = 0, hold reed low, and leave busy low.
REQ-016 load during CALC SHALL abort and restart the division with the newly sampled operands (busy stays high, 25 fresh cycles).
REQ-017 load during RUN SHALL continue pulsing at the old period until the new period is applied.
REQ-018 In RUN, a 16-bit counter SHALL count 0..period-1; reed is high for exactly one cycle when the counter equals period-1, then it wraps to 0.
REQ-019 On entering RUN (new period applied), the counter SHALL restart at 0, so the first pulse occurs period cycles after busy falls.
REQ-020 Successive reed rising edges in steady RUN SHALL be exactly period clocks apart.
REQ-021 circ == 0 with speed != 0 SHALL yield Q = 0, clamped to 2 per REQ-014.

Reset
REQ-022 Asserting reset low SHALL immediately force state IDLE, reed = 0, busy = 0, period = 0, the counter and divider registers to 0, and the latched operands to 0, regardless of any operation in progress.
REQ-023 After reset deasserts, the block SHALL remain in IDLE until the first load.

Configuration
REQ-024 Macro REED_PULSE_GEN_BOUNCE_EN: when defined, each reed event SHALL be a 3-cycle pattern 1,0,1 starting at counter == period-1 (contact-bounce emulation), and period SHALL be clamped to a minimum of 4.
REQ-025 When REED_PULSE_GEN_BOUNCE_EN is undefined, reed SHALL be the single-cycle pulse of REQ-018, and the minimum period SHALL be 2.

Verification
REQ-026 Scenario: circ=255, speed=30, load -> busy high 25 cycles; period=627; reed pulses every 627 clocks.
REQ-027 Scenario: circ=200, speed=36, load -> period=410; first reed 410 cycles after busy falls.
REQ-028 Scenario: circ=255, speed=1 -> period=18801; circ=1, speed=255 -> Q=0, period=2 (4 with REED_PULSE_GEN_BOUNCE_EN).
REQ-029 Scenario: RUN at period 627, then load speed=0 -> next cycle IDLE, period=0, no further reed.
REQ-030 Scenario: load speed=30, then 10 cycles later load speed=60 (circ=255) -> busy is continuous for 35 cycles in total; final period=313.
REQ-031 Scenario: reset pulsed low mid-CALC and mid-RUN -> outputs are 0 within the same cycle, and there is no reed until the next load.
